// File: rtl/nanorv32_pkg.sv
// ---------------------------------------------------------------------------
// nanorv32_pkg
// Shared definitions for the nanorv32 memory-bus arbiter:
//   - arb_state_e       : arbiter FSM states (idle, transfer in flight, error)
//   - ERR_RDATA_DEFAULT : read data handed back on a watchdog-terminated transfer
//   - arb_pick()        : tie-break helper returning the winning master index
// ---------------------------------------------------------------------------
package nanorv32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ERR  = 2'd2
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

    // Returns 1 when master 1 should be granted. A lone m1 request wins
    // outright; on a tie m1 wins only under rotation and only if m0 was
    // granted last.
    function automatic logic arb_pick(input logic req1, input logic both,
                                      input logic last, input bit rr_en);
        return both ? (rr_en & ~last) : req1;
    endfunction

endpackage

// File: rtl/nanorv32_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// nanorv32_mem_arbiter_if
// One nanorv32 native memory-bus link (request fields plus the response).
//   valid  : request, held with stable fields until ready
//   instr  : instruction-fetch qualifier
//   addr   : byte address
//   wdata  : write data
//   wstrb  : byte strobes, 0 means read
//   ready  : one-cycle completion pulse
//   rdata  : read data, valid while ready is high
// Modports: master drives the request, slave drives the response.
// ---------------------------------------------------------------------------
interface nanorv32_mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb,
                    input  ready, rdata);
    modport slave  (input  valid, instr, addr, wdata, wstrb,
                    output ready, rdata);
endinterface

// File: rtl/nanorv32_arb_wdog.sv
// ---------------------------------------------------------------------------
// nanorv32_arb_wdog
// Watchdog counter for the arbiter. Counts enabled cycles from zero,
// saturates at TIMEOUT, and flags expiry on the TIMEOUT-th enabled cycle.
//   clk       : clock
//   resetn    : synchronous active-low reset
//   clr_i     : clear counter to zero (dominates en_i)
//   en_i      : count this cycle
//   expired_o : high while enabled and count == TIMEOUT-1
// ---------------------------------------------------------------------------
module nanorv32_arb_wdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/nanorv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nanorv32_mem_arbiter
// Two-master / one-slave arbiter for the nanorv32 native memory bus. The
// grant is held for a whole transfer and the response goes only to the
// owner. A watchdog ends transfers the slave never acknowledges.
//   clk      : clock
//   resetn   : synchronous active-low reset
//   m0       : master 0 link (core memory port), slave modport
//   m1       : master 1 link (DMA / debug loader), slave modport
//   mem      : link to the memory or fabric, master modport
//   bus_err  : one-cycle pulse when the watchdog terminates a transfer
// Parameters: TIMEOUT (BUSY cycles before termination, 0 disables the
// watchdog), ERR_RDATA (read data returned on termination).
// Build option: define NANORV32_ARB_ROUND_ROBIN_EN to alternate ties
// between masters; otherwise master 0 always wins a tie.
// ---------------------------------------------------------------------------
module nanorv32_mem_arbiter
    import nanorv32_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                          clk,
    input  logic                          resetn,
    nanorv32_mem_arbiter_if.slave         m0,
    nanorv32_mem_arbiter_if.slave         m1,
    nanorv32_mem_arbiter_if.master        mem,
    output logic                          bus_err
);
`ifdef NANORV32_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_e  state_q;
    logic        owner_q;
    logic        last_q;

    logic        busy, in_err, expired;
    logic        any_req, both_req, winner;
    logic        owner_valid, sel_m1, done, rsp_fire;
    logic [31:0] rsp_data;

    assign any_req     = m0.valid | m1.valid;
    assign both_req    = m0.valid & m1.valid;
    assign winner      = arb_pick(m1.valid, both_req, last_q, RR_EN);

    assign busy        = (state_q == ARB_BUSY);
    assign in_err      = (state_q == ARB_ERR);
    assign owner_valid = owner_q ? m1.valid : m0.valid;
    assign done        = busy & owner_valid & mem.ready;

    // Outside BUSY the slave sees master 0's fields with valid low.
    assign sel_m1      = busy & owner_q;
    assign mem.valid   = busy & owner_valid & resetn;
    assign mem.instr   = sel_m1 ? m1.instr : m0.instr;
    assign mem.addr    = sel_m1 ? m1.addr  : m0.addr;
    assign mem.wdata   = sel_m1 ? m1.wdata : m0.wdata;
    assign mem.wstrb   = sel_m1 ? m1.wstrb : m0.wstrb;

    // Responses are gated by resetn so a transfer caught by reset is
    // abandoned without a completion pulse in the reset cycle itself.
    assign rsp_fire    = resetn & (done | in_err);
    assign rsp_data    = in_err ? ERR_RDATA : mem.rdata;
    assign m0.ready    = rsp_fire & ~owner_q;
    assign m1.ready    = rsp_fire &  owner_q;
    assign m0.rdata    = m0.ready ? rsp_data : '0;
    assign m1.rdata    = m1.ready ? rsp_data : '0;
    assign bus_err     = resetn & in_err;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register in this block sees pre-edge values.
        if (!resetn) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        last_q  <= winner;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A dropped valid is a master protocol violation:
                    // abandon the transfer silently.
                    if (done || !owner_valid) begin
                        state_q <= ARB_IDLE;
                    end else if (expired) begin
                        state_q <= ARB_ERR;
                    end
                end
                ARB_ERR: state_q <= ARB_IDLE;
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_wdog
            nanorv32_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
                .clk       (clk),
                .resetn    (resetn),
                .clr_i     (!busy),
                .en_i      (busy),
                .expired_o (expired)
            );
        end else begin : g_no_wdog
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: doc/nanorv32_mem_arbiter.md
# nanorv32_mem_arbiter

Two-master, one-slave arbiter for the nanorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata/instr). It sits between the core's memory port (master 0) and a secondary requester such as a DMA or debug loader (master 1), and the single memory/MMIO model or fabric. It holds a grant for a whole transfer and forwards the response only to the owner. A watchdog terminates transfers the slave never acknowledges.

## Interface
- TIMEOUT, 64: cycles in BUSY without `mem_ready` before forced termination; 0 disables the watchdog.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned to the owner on a timed-out transfer.
- clk  input  1  sole clock; all state updates on posedge.
- resetn  input  1  reset, synchronous, active-low.
- m0_valid / m1_valid  input  1  master request; held high with stable fields until that master's ready.
- m0_instr / m1_instr  input  1  instruction-fetch qualifier.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte strobes; 0 means read.
- m0_ready / m1_ready  output  1  one-cycle completion pulse to the owner.
- m0_rdata / m1_rdata  output  32  read data, valid while the matching ready is high.
- mem_valid  output  1  slave request.
- mem_instr, mem_addr, mem_wdata, mem_wstrb  output  1/32/32/4  owner's fields, muxed.
- mem_ready  input  1  slave completion.
- mem_rdata  input  32  slave read data.
- bus_err  output  1  one-cycle pulse on watchdog termination.

## Operation
- FSM states: IDLE, BUSY, ERR. Registers: `owner` (1 bit), `last` (1 bit, last granted master), watchdog counter.
- IDLE: if any `mX_valid`, latch the winner into `owner` and go to BUSY. Otherwise stay.
- Arbitration: one requester wins outright. When both request, the choice follows Configuration. `last` <= winner.
- BUSY: `mem_valid` = `owner`'s valid. `mem_*` fields = `owner`'s fields. Counter increments each cycle.
  - On `mem_ready`: `m<owner>_ready` = 1 (combinational pass-through) and `m<owner>_rdata` = `mem_rdata`. Next state IDLE, counter cleared.
  - If the owner drops valid without ready (protocol violation): return to IDLE and issue no ready.
- Timeout: counter == TIMEOUT-1 with no `mem_ready` (TIMEOUT≠0) moves to ERR and drops `mem_valid`.
- ERR (one cycle): `m<owner>_ready` = 1, `m<owner>_rdata` = ERR_RDATA, `bus_err` = 1. Next state IDLE.
- `mem_ready` arriving outside BUSY is ignored and never forwarded.
- The non-owner's ready is always 0. Non-owner rdata = 0.
- In IDLE/ERR the `mem_*` fields are driven from master 0 with `mem_valid` = 0.
- Reset (any state, including mid-transfer): state IDLE, owner 0, `last` 1, counter 0. All outputs 0; an in-flight transfer is abandoned with no ready.

## Timing
- Grant is registered, so one arbitration cycle is added. Valid at edge N gives `mem_valid` in cycle N+1.
- With the registered-ready memory model, ready reaches the owner in cycle N+2 and the FSM is back in IDLE in cycle N+3. End-to-end latency is 3 cycles vs 2 direct.
- Back-to-back requests from the same master are separated by at least one IDLE cycle.
- Timeout path: ready to the owner in cycle N+1+TIMEOUT.
- Width of the watchdog counter is $clog2(TIMEOUT+1); it saturates and does not wrap.

## Configuration
- NANORV32_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the master ≠ `last` wins. Reset `last`=1 means m0 wins the first tie.
- Undefined: fixed priority, m0 always wins a tie. `last` is still maintained but is not used for arbitration.

## Structure
- Shared package `nanorv32_pkg`: FSM state enum (ARB_IDLE, ARB_BUSY, ARB_ERR) and the default ERR_RDATA constant.
- One sub-module, `nanorv32_arb_wdog`: clear/enable counter with a `expired` output. It is instantiated only when TIMEOUT≠0.

## Test plan
- m0 read 0x0000_0010 alone, memory returns 0x1234_5678 → `mem_valid` in N+1, `m0_ready`=1 and `m0_rdata`=0x1234_5678 in N+2, `m1_ready` stays 0.
- m0 and m1 request in the same cycle, round-robin macro defined, three tie rounds → grant order m0, m1, m0. With the macro undefined → m0, m0, m0.
- m1 write 0x1000_0000 wdata=0x41 wstrb=4'b0001 while m0 idle → slave sees exactly those fields, m1 receives one ready pulse.
- TIMEOUT=8, slave never ready → `bus_err` and `m0_ready` pulse in cycle N+9 with rdata 0xFFFF_FFFF. A late `mem_ready` in N+12 is not forwarded.
- `resetn` low for one cycle during BUSY → next cycle IDLE and `mem_valid`=0. The pending master gets no ready; its re-issued request completes normally.
- m0 holds valid continuously through three transfers → exactly three ready pulses, each followed by one IDLE cycle.
